// File: rtl/garage_pkg.sv
// Shared types and constants for the garage door controller and its plant model.
// Holds the door mechanism state encoding, the controller state encoding,
// default timing constants and a width helper.
package garage_pkg;

  typedef enum logic [2:0] {
    DOOR_STOPPED   = 3'd0,
    DOOR_SPINUP_UP = 3'd1,
    DOOR_SPINUP_DN = 3'd2,
    DOOR_RUN_UP    = 3'd3,
    DOOR_RUN_DN    = 3'd4,
    DOOR_FAULT     = 3'd5
  } door_state_e;

  typedef enum logic [2:0] {
    CTRL_IDLE    = 3'd0,
    CTRL_OPENING = 3'd1,
    CTRL_OPEN    = 3'd2,
    CTRL_CLOSING = 3'd3,
    CTRL_CLOSED  = 3'd4,
    CTRL_ERROR   = 3'd5
  } ctrl_state_e;

  // Bits needed to hold every value in 0..max_val (never less than 1).
  function automatic int unsigned width_for(input int unsigned max_val);
    int unsigned w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

  localparam int unsigned DEF_TRAVEL_TICKS = 1000;
  localparam int unsigned DEF_PRESCALE     = 100;
  localparam int unsigned DEF_START_DELAY  = 4;
  localparam int unsigned DEF_POS_W        = width_for(DEF_TRAVEL_TICKS);

endpackage

// File: rtl/garage_door_plant_step_timer.sv
// Up-counter shared by spin-up and prescale timing.
//   clk, reset : clock, synchronous active-high reset
//   clr        : force the count to 0 (takes priority over en)
//   en         : advance the count this cycle
//   tc         : terminal count; the count wraps to 0 after reaching it
//   tc_pulse   : single-cycle pulse while enabled and sitting at tc
module step_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] tc,
  output logic             tc_pulse
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    tc_pulse = en && !clr && (cnt_q == tc);
    cnt_d    = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en)
      cnt_d = tc_pulse ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/garage_door_plant.sv
// Stand-in for the physical garage door: turns motor commands into position
// and limit-switch signals, with spin-up delay, finite travel, end-stop
// saturation and a latched fault on contradictory commands.
//   clk, reset     : clock, synchronous active-high reset
//   up_m, dn_m     : motor drive toward open / closed
//   up_max, dn_max : limit switches (pos at full open / closed)
//   pos            : door position, 0 = closed
//   moving         : motor running (RUN_UP / RUN_DN)
//   fault          : both commands seen together; cleared only by reset
module garage_door_plant
  import garage_pkg::*;
#(
  parameter int unsigned TRAVEL_TICKS = DEF_TRAVEL_TICKS,
  parameter int unsigned PRESCALE     = DEF_PRESCALE,
  parameter int unsigned START_DELAY  = DEF_START_DELAY,
  parameter int unsigned POS_W        = DEF_POS_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             up_m,
  input  logic             dn_m,
  output logic             up_max,
  output logic             dn_max,
  output logic [POS_W-1:0] pos,
  output logic             moving,
  output logic             fault
);

  localparam int unsigned CNT_MAX = (PRESCALE > START_DELAY) ? PRESCALE - 1 : START_DELAY - 1;
  localparam int unsigned CNT_W   = width_for(CNT_MAX);

  door_state_e      state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             up_max_q, dn_max_q;
  logic             tmr_clr, tmr_en, tmr_tc;
  logic [CNT_W-1:0] tmr_limit;

  // Spin-up and prescale never overlap, so one counter serves both; it wraps
  // to 0 on its terminal pulse, which also clears it on entry to RUN_x.
  assign tmr_limit = (state_q == DOOR_SPINUP_UP || state_q == DOOR_SPINUP_DN)
                     ? CNT_W'(START_DELAY - 1) : CNT_W'(PRESCALE - 1);

  step_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clr      (tmr_clr),
    .en       (tmr_en),
    .tc       (tmr_limit),
    .tc_pulse (tmr_tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= DOOR_STOPPED;
      pos_q    <= '0;
      up_max_q <= 1'b0;
      dn_max_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      // Limits follow the new position on the same edge.
      up_max_q <= (pos_d == POS_W'(TRAVEL_TICKS));
      dn_max_q <= (pos_d == '0);
    end
  end

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    tmr_clr = 1'b1;
    tmr_en  = 1'b0;
    if (state_q != DOOR_FAULT && up_m && dn_m) begin
      state_d = DOOR_FAULT;
    end else begin
      unique case (state_q)
        DOOR_STOPPED: begin
          if (up_m)      state_d = DOOR_SPINUP_UP;
          else if (dn_m) state_d = DOOR_SPINUP_DN;
        end
        DOOR_SPINUP_UP, DOOR_SPINUP_DN: begin
          if ((state_q == DOOR_SPINUP_UP) ? !up_m : !dn_m) begin
            state_d = DOOR_STOPPED;
          end else begin
            tmr_clr = 1'b0;
            tmr_en  = 1'b1;
            if (tmr_tc)
              state_d = (state_q == DOOR_SPINUP_UP) ? DOOR_RUN_UP : DOOR_RUN_DN;
          end
        end
        DOOR_RUN_UP: begin
          if (!up_m) begin
            state_d = DOOR_STOPPED;
          end else begin
            tmr_clr = 1'b0;
            tmr_en  = 1'b1;
            if (tmr_tc && pos_q != POS_W'(TRAVEL_TICKS)) pos_d = pos_q + POS_W'(1);
          end
        end
        DOOR_RUN_DN: begin
          if (!dn_m) begin
            state_d = DOOR_STOPPED;
          end else begin
            tmr_clr = 1'b0;
            tmr_en  = 1'b1;
            if (tmr_tc && pos_q != '0) pos_d = pos_q - POS_W'(1);
          end
        end
        DOOR_FAULT: state_d = DOOR_FAULT;
        default:    state_d = DOOR_STOPPED;
      endcase
    end
  end

  always_comb begin
    moving = (state_q == DOOR_RUN_UP) || (state_q == DOOR_RUN_DN);
    fault  = (state_q == DOOR_FAULT);
  end

  assign pos    = pos_q;
  assign up_max = up_max_q;
  assign dn_max = dn_max_q;

endmodule

// File: tb/tb_garage_door_plant.sv
module tb_garage_door_plant;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       up_m = 1'b0;
  logic       dn_m = 1'b0;
  logic       up_max, dn_max, moving, fault;
  logic [3:0] pos;

  int checks = 0;
  int failures = 0;

  garage_door_plant #(
    .TRAVEL_TICKS(8),
    .PRESCALE    (2),
    .START_DELAY (3),
    .POS_W       (4)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .up_m   (up_m),
    .dn_m   (dn_m),
    .up_max (up_max),
    .dn_max (dn_max),
    .pos    (pos),
    .moving (moving),
    .fault  (fault)
  );

  always #5 clk = ~clk;

  // Advance past the next rising edge; outputs are sampled 1 time unit later.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int e_pos, input logic e_up, input logic e_dn,
                         input logic e_mov, input logic e_flt);
    chk({tag, ".pos"},    32'(pos),    32'(e_pos));
    chk({tag, ".up_max"}, 32'(up_max), 32'(e_up));
    chk({tag, ".dn_max"}, 32'(dn_max), 32'(e_dn));
    chk({tag, ".moving"}, 32'(moving), 32'(e_mov));
    chk({tag, ".fault"},  32'(fault),  32'(e_flt));
  endtask

  task automatic do_reset();
    reset = 1'b1; up_m = 1'b0; dn_m = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    // Reset state
    tick();
    reset = 1'b0;
    chk_out("reset", 0, 0, 1, 0, 0);

    // Full open run; e0 is the first edge sampling up_m
    up_m = 1'b1;
    tick();     chk_out("up_e0", 0, 0, 1, 0, 0);
    tick(2);    chk_out("up_e2", 0, 0, 1, 0, 0);
    tick();     chk_out("up_e3", 0, 0, 1, 1, 0);
    tick();     chk_out("up_e4", 0, 0, 1, 1, 0);
    tick();     chk_out("up_e5", 1, 0, 0, 1, 0);
    tick(13);   chk_out("up_e18", 7, 0, 0, 1, 0);
    tick();     chk_out("up_e19", 8, 1, 0, 1, 0);
    tick(6);    chk_out("up_e25_stall", 8, 1, 0, 1, 0);

    // Stop, then full close run
    up_m = 1'b0;
    tick();     chk_out("stop_top", 8, 1, 0, 0, 0);
    dn_m = 1'b1;
    tick(4);    chk_out("dn_e3", 8, 1, 0, 1, 0);
    tick();     chk_out("dn_e4", 8, 1, 0, 1, 0);
    tick();     chk_out("dn_e5", 7, 0, 0, 1, 0);
    tick(13);   chk_out("dn_e18", 1, 0, 0, 1, 0);
    tick();     chk_out("dn_e19", 0, 0, 1, 1, 0);
    tick(11);   chk_out("dn_e30_stall", 0, 0, 1, 1, 0);

    // Partial open, stop at pos=3, resume
    dn_m = 1'b0;
    tick();     chk_out("stop_bot", 0, 0, 1, 0, 0);
    up_m = 1'b1;
    tick(10);   chk_out("part_e9", 3, 0, 0, 1, 0);
    up_m = 1'b0;
    tick();     chk_out("part_stop", 3, 0, 0, 0, 0);
    tick(2);    chk_out("part_hold", 3, 0, 0, 0, 0);
    up_m = 1'b1;
    tick(5);    chk_out("resume_e4", 3, 0, 0, 1, 0);
    tick();     chk_out("resume_e5", 4, 0, 0, 1, 0);

    // Direction change during spin-up must pass through STOPPED
    do_reset();
    up_m = 1'b1;
    tick(2);    chk_out("rev_e1", 0, 0, 1, 0, 0);
    up_m = 1'b0; dn_m = 1'b1;
    tick();     chk_out("rev_e2", 0, 0, 1, 0, 0);
    tick();     chk_out("rev_e3", 0, 0, 1, 0, 0);
    tick(2);    chk_out("rev_e5", 0, 0, 1, 0, 0);
    tick();     chk_out("rev_e6_run", 0, 0, 1, 1, 0);

    // Illegal command while running at pos=5
    do_reset();
    up_m = 1'b1;
    tick(14);   chk_out("flt_e13", 5, 0, 0, 1, 0);
    dn_m = 1'b1;
    tick();     chk_out("flt_entry", 5, 0, 0, 0, 1);
    for (int i = 0; i < 20; i++) begin
      up_m = 1'($urandom_range(0, 1));
      dn_m = 1'($urandom_range(0, 1));
      tick();
      chk("flt_hold.pos", 32'(pos), 32'd5);
      chk("flt_hold.fault", 32'(fault), 32'd1);
    end
    chk("flt_hold.moving", 32'(moving), 32'd0);
    do_reset();
    chk_out("flt_reset", 0, 0, 1, 0, 0);

    // Synchronous reset mid-run; glitch between edges ignored
    up_m = 1'b1;
    tick(12);   chk_out("rst_e11", 4, 0, 0, 1, 0);
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    tick();     chk_out("rst_glitch", 4, 0, 0, 1, 0);
    reset = 1'b1;
    tick();     chk_out("rst_sync", 0, 0, 1, 0, 0);
    reset = 1'b0; up_m = 1'b0;
    tick(3);    chk_out("rst_after", 0, 0, 1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
